// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if
// Bundles the MEM-stage pipeline inputs, the data-memory handshake and the
// controller results into one interface.
//   slave  : the controller side (takes pipeline and memory inputs,
//            drives requests, stall, load data and the error flag)
//   master : the environment side (pipeline register and memory model)
interface mem_stage_ctrl_if #(
  parameter int OPCODE_W = 5,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16
);
  // Pipeline side
  logic                valid_in;
  logic                flush;
  logic [OPCODE_W-1:0] opcode;
  logic [ADDR_W-1:0]   addr_in;
  logic [DATA_W-1:0]   wdata_in;
  // Memory side
  logic                mem_busy;
  logic                mem_done;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_rd;
  logic                mem_wr;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  // Results
  logic                stall_pipe;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_valid;
  logic                err;

  modport slave (
    input  valid_in, flush, opcode, addr_in, wdata_in,
    input  mem_busy, mem_done, mem_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    output stall_pipe, rd_data, rd_valid, err
  );

  modport master (
    output valid_in, flush, opcode, addr_in, wdata_in,
    output mem_busy, mem_done, mem_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    input  stall_pipe, rd_data, rd_valid, err
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
// Multi-cycle MEM-stage controller. Decodes the MEM opcode into a load or
// store, issues a latched request to a variable-latency memory, stalls the
// pipeline until the access completes, returns load data with a one-cycle
// valid strobe, and raises a sticky error when the memory times out.
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rst    : synchronous active-high reset
//   mem_if : mem_stage_ctrl_if.slave (pipeline inputs, memory handshake,
//            stall_pipe, rd_data/rd_valid, err)
module mem_stage_ctrl #(
  parameter int OPCODE_W = 5,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 15   // 1..255, limited by the 8-bit counter
) (
  input  logic              clk,
  input  logic              rst,
  mem_stage_ctrl_if.slave   mem_if
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  // Last counter value allowed in WAIT before declaring a timeout.
  localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

  state_t              state_q;
  logic [7:0]          cnt_q;
  logic                is_rd_q;
  logic                mem_rd_q;
  logic                mem_wr_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                stall_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;
  logic                err_q;

  logic [OPCODE_W-1:0] opcode;
  logic                rd_op;
  logic                wr_op;
  logic                accept;

  // Only the low five opcode bits select the access kind.
  assign opcode = mem_if.opcode;
  assign rd_op  = (opcode[4:0] == 5'b10001);                             // LD
  assign wr_op  = (opcode[4:0] == 5'b10000) || (opcode[4:0] == 5'b10011); // ST, STU

  assign accept = (state_q == S_IDLE) && mem_if.valid_in && !mem_if.flush
                  && (rd_op || wr_op);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      is_rd_q     <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      stall_q     <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // rd_valid is a strobe: it is only ever set on the edge entering DONE.
      rd_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            mem_addr_q  <= mem_if.addr_in;
            mem_wdata_q <= mem_if.wdata_in;
            is_rd_q     <= rd_op;
            mem_rd_q    <= rd_op;
            mem_wr_q    <= wr_op;
            stall_q     <= 1'b1;
            state_q     <= S_REQ;
          end
        end
        S_REQ: begin
          // A busy memory holds the request even if it also signals done.
          if (!mem_if.mem_busy) begin
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            if (mem_if.mem_done) begin
              stall_q <= 1'b0;
              state_q <= S_DONE;
              if (is_rd_q) begin
                rd_data_q  <= mem_if.mem_rdata;
                rd_valid_q <= 1'b1;
              end
            end else begin
              cnt_q   <= 8'd0;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Completion on the limit cycle still counts as success.
          if (mem_if.mem_done) begin
            stall_q <= 1'b0;
            state_q <= S_DONE;
            if (is_rd_q) begin
              rd_data_q  <= mem_if.mem_rdata;
              rd_valid_q <= 1'b1;
            end
          end else if (cnt_q == CNT_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        S_ERR: begin
          // Locked with the pipeline stalled until reset.
          state_q <= S_ERR;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_if.mem_rd     = mem_rd_q;
  assign mem_if.mem_wr     = mem_wr_q;
  assign mem_if.mem_addr   = mem_addr_q;
  assign mem_if.mem_wdata  = mem_wdata_q;
  // The stall must rise in the accept cycle itself, before any register update.
  assign mem_if.stall_pipe = accept || stall_q;
  assign mem_if.rd_data    = rd_data_q;
  assign mem_if.rd_valid   = rd_valid_q;
  assign mem_if.err        = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl
// Randomized scenarios checked cycle by cycle against a transaction-level
// timeline model: for each access the expected cycle of every event
// (request window, completion, timeout) is computed arithmetically from the
// busy length and the memory response delay.
module tb_mem_stage_ctrl;
  localparam int MW = 4;
  localparam logic [4:0] OP_LD   = 5'b10001;
  localparam logic [4:0] OP_ST   = 5'b10000;
  localparam logic [4:0] OP_STU  = 5'b10011;
  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_HALT = 5'b00000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  // Model of the values the latched outputs should hold between accesses.
  logic [15:0] last_addr;
  logic [15:0] last_wdata;
  logic [15:0] last_rd;

  mem_stage_ctrl_if #(.OPCODE_W(5), .ADDR_W(16), .DATA_W(16)) bus_if();

  mem_stage_ctrl #(
    .OPCODE_W(5), .ADDR_W(16), .DATA_W(16), .MAX_WAIT(MW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .mem_if (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] rand_nonmem();
    logic [4:0] o;
    do o = 5'($urandom_range(0, 31));
    while (o == OP_LD || o == OP_ST || o == OP_STU);
    return o;
  endfunction

  function automatic logic [4:0] rand_memop();
    int k;
    k = $urandom_range(0, 2);
    return (k == 0) ? OP_LD : ((k == 1) ? OP_ST : OP_STU);
  endfunction

  task automatic idle_inputs();
    bus_if.valid_in  = 1'b0;
    bus_if.flush     = 1'b0;
    bus_if.opcode    = 5'd0;
    bus_if.addr_in   = 16'd0;
    bus_if.wdata_in  = 16'd0;
    bus_if.mem_busy  = 1'b0;
    bus_if.mem_done  = 1'b0;
    bus_if.mem_rdata = 16'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    last_addr  = 16'd0;
    last_wdata = 16'd0;
    last_rd    = 16'd0;
  endtask

  // One memory access. done_k: 0 = done in the last REQ cycle (single-cycle
  // memory), 1..MW = done in that WAIT cycle, >MW = memory never answers.
  task automatic test_access(input string name, input logic [4:0] op,
                             input logic [15:0] a, input logic [15:0] wd,
                             input logic [15:0] rdat, input int busy_n,
                             input int done_k, input bit flush_mid);
    bit is_rd, to;
    int done_cyc, t_done, t_err, t_end, errs0;
    bit e_stall, e_rd, e_wr, e_rv, e_err;
    logic [15:0] e_addr, e_wdata, e_rdata;
    is_rd    = (op == OP_LD);
    to       = (done_k > MW);
    done_cyc = (done_k == 0) ? busy_n + 1 : busy_n + 1 + done_k;
    t_done   = to ? -1 : done_cyc + 1;
    t_err    = busy_n + 2 + MW;
    t_end    = to ? t_err + 2 : t_done + 1;
    errs0    = n_errors;
    for (int c = 0; c <= t_end; c++) begin
      // Stimulus: only cycle 0 carries the real access; later cycles carry
      // noise that the controller must ignore.
      bus_if.valid_in  = (c != t_end);
      bus_if.opcode    = (c == 0) ? op : ((c == t_done) ? OP_LD : 5'($urandom));
      bus_if.flush     = (c == 0 || c == t_done) ? 1'b0
                         : (flush_mid ? 1'b1 : 1'($urandom_range(0, 1)));
      bus_if.addr_in   = (c == 0) ? a  : 16'($urandom);
      bus_if.wdata_in  = (c == 0) ? wd : 16'($urandom);
      bus_if.mem_busy  = (c >= 1 && c <= busy_n);
      if (!to && c == done_cyc)
        bus_if.mem_done = 1'b1;
      else if (c == 0 || (c >= 1 && c <= busy_n) || c == t_done || (to && c >= t_err))
        bus_if.mem_done = 1'($urandom_range(0, 1));
      else
        bus_if.mem_done = 1'b0;
      bus_if.mem_rdata = (c == done_cyc) ? rdat : 16'($urandom);

      e_stall = to ? 1'b1 : (c < t_done);
      e_rd    = is_rd  && c >= 1 && c <= busy_n + 1;
      e_wr    = !is_rd && c >= 1 && c <= busy_n + 1;
      e_addr  = (c == 0) ? last_addr  : a;
      e_wdata = (c == 0) ? last_wdata : wd;
      e_rv    = !to && is_rd && c == t_done;
      e_rdata = (!to && is_rd && c >= t_done) ? rdat : last_rd;
      e_err   = to && c >= t_err;

      @(negedge clk);
      n_checks += 8;
      if (bus_if.stall_pipe !== e_stall) begin
        n_errors++;
        $display("FAIL %s cyc%0d stall_pipe got %b exp %b", name, c, bus_if.stall_pipe, e_stall);
      end
      if (bus_if.mem_rd !== e_rd) begin
        n_errors++;
        $display("FAIL %s cyc%0d mem_rd got %b exp %b", name, c, bus_if.mem_rd, e_rd);
      end
      if (bus_if.mem_wr !== e_wr) begin
        n_errors++;
        $display("FAIL %s cyc%0d mem_wr got %b exp %b", name, c, bus_if.mem_wr, e_wr);
      end
      if (bus_if.mem_addr !== e_addr) begin
        n_errors++;
        $display("FAIL %s cyc%0d mem_addr got %h exp %h", name, c, bus_if.mem_addr, e_addr);
      end
      if (bus_if.mem_wdata !== e_wdata) begin
        n_errors++;
        $display("FAIL %s cyc%0d mem_wdata got %h exp %h", name, c, bus_if.mem_wdata, e_wdata);
      end
      if (bus_if.rd_valid !== e_rv) begin
        n_errors++;
        $display("FAIL %s cyc%0d rd_valid got %b exp %b", name, c, bus_if.rd_valid, e_rv);
      end
      if (bus_if.rd_data !== e_rdata) begin
        n_errors++;
        $display("FAIL %s cyc%0d rd_data got %h exp %h", name, c, bus_if.rd_data, e_rdata);
      end
      if (bus_if.err !== e_err) begin
        n_errors++;
        $display("FAIL %s cyc%0d err got %b exp %b", name, c, bus_if.err, e_err);
      end
      @(posedge clk);
      #1;
    end
    idle_inputs();
    last_addr  = a;
    last_wdata = wd;
    if (is_rd && !to) last_rd = rdat;
    $display("txn %s op=%b addr=%h wdata=%h busy=%0d done_k=%0d %s errors=%0d",
             name, op, a, wd, busy_n, done_k, to ? "timeout" : "done", n_errors - errs0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({bus_if.mem_rd, bus_if.mem_wr, bus_if.mem_addr, bus_if.mem_wdata, bus_if.stall_pipe,
         bus_if.rd_data, bus_if.rd_valid, bus_if.err} !== 53'd0) begin
      n_errors++;
      $display("FAIL reset outputs got rd=%b wr=%b addr=%h wdata=%h stall=%b rdata=%h rv=%b err=%b exp all 0",
               bus_if.mem_rd, bus_if.mem_wr, bus_if.mem_addr, bus_if.mem_wdata,
               bus_if.stall_pipe, bus_if.rd_data, bus_if.rd_valid, bus_if.err);
    end
    @(posedge clk);
    #1;
    $display("txn reset_state");
  endtask

  task automatic test_nonmem();
    logic [4:0] ops [8];
    ops[0] = OP_ADDI;
    ops[1] = OP_HALT;
    for (int i = 2; i < 8; i++) ops[i] = rand_nonmem();
    for (int i = 0; i < 8; i++) begin
      bus_if.valid_in  = 1'b1;
      bus_if.opcode    = ops[i];
      bus_if.addr_in   = 16'($urandom);
      bus_if.wdata_in  = 16'($urandom);
      bus_if.mem_done  = 1'($urandom_range(0, 1));
      bus_if.mem_rdata = 16'($urandom);
      @(negedge clk);
      n_checks += 3;
      if (bus_if.stall_pipe !== 1'b0) begin
        n_errors++;
        $display("FAIL nonmem op=%b stall_pipe got %b exp 0", ops[i], bus_if.stall_pipe);
      end
      if ({bus_if.mem_rd, bus_if.mem_wr} !== 2'b00) begin
        n_errors++;
        $display("FAIL nonmem op=%b rd/wr got %b%b exp 00", ops[i], bus_if.mem_rd, bus_if.mem_wr);
      end
      if (bus_if.mem_addr !== last_addr) begin
        n_errors++;
        $display("FAIL nonmem op=%b mem_addr got %h exp %h", ops[i], bus_if.mem_addr, last_addr);
      end
      @(posedge clk);
      #1;
      $display("txn nonmem op=%b", ops[i]);
    end
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if ({bus_if.mem_rd, bus_if.mem_wr, bus_if.stall_pipe, bus_if.rd_valid} !== 4'b0000) begin
      n_errors++;
      $display("FAIL nonmem_after rd/wr/stall/rv got %b%b%b%b exp 0000",
               bus_if.mem_rd, bus_if.mem_wr, bus_if.stall_pipe, bus_if.rd_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_flush();
    bus_if.valid_in = 1'b1;
    bus_if.flush    = 1'b1;
    bus_if.opcode   = OP_STU;
    bus_if.addr_in  = 16'h7777;
    bus_if.wdata_in = 16'h1111;
    @(negedge clk);
    n_checks++;
    if (bus_if.stall_pipe !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_idle stall_pipe got %b exp 0", bus_if.stall_pipe);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if ({bus_if.mem_wr, bus_if.stall_pipe, bus_if.mem_addr} !== {2'b00, last_addr}) begin
      n_errors++;
      $display("FAIL flush_idle wr/stall/addr got %b%b %h exp 00 %h",
               bus_if.mem_wr, bus_if.stall_pipe, bus_if.mem_addr, last_addr);
    end
    @(posedge clk);
    #1;
    $display("txn flush_idle op=%b", OP_STU);
    test_access("flush_wait", OP_LD, 16'h2468, 16'h0, 16'h5A5A, 1, 2, 1'b1);
  endtask

  task automatic test_single_cycle();
    test_access("single_ld", OP_LD, 16'h0F0F, 16'h0, 16'hC3C3, 0, 0, 1'b0);
    test_access("single_st", OP_ST, 16'hF0F0, 16'h9999, 16'h0, 2, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      test_access("random", rand_memop(), 16'($urandom), 16'($urandom), 16'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, MW), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    bus_if.valid_in = 1'b1;
    bus_if.opcode   = OP_LD;
    bus_if.addr_in  = 16'h3C3C;
    @(posedge clk);
    #1;
    bus_if.valid_in = 1'b0;                 // cycle 1: REQ
    @(posedge clk);
    #1;                                     // cycle 2: WAIT
    @(negedge clk);
    n_checks++;
    if (bus_if.stall_pipe !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid wait stall_pipe got %b exp 1", bus_if.stall_pipe);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus_if.mem_rd, bus_if.mem_wr, bus_if.mem_addr, bus_if.mem_wdata, bus_if.stall_pipe,
         bus_if.rd_data, bus_if.rd_valid, bus_if.err} !== 53'd0) begin
      n_errors++;
      $display("FAIL reset_mid outputs got rd=%b wr=%b addr=%h wdata=%h stall=%b rdata=%h rv=%b err=%b exp all 0",
               bus_if.mem_rd, bus_if.mem_wr, bus_if.mem_addr, bus_if.mem_wdata,
               bus_if.stall_pipe, bus_if.rd_data, bus_if.rd_valid, bus_if.err);
    end
    bus_if.mem_done  = 1'b1;
    bus_if.mem_rdata = 16'hDEAD;
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if ({bus_if.stall_pipe, bus_if.rd_valid, bus_if.rd_data} !== 18'd0) begin
      n_errors++;
      $display("FAIL reset_mid late_done stall/rv/rdata got %b%b %h exp 00 0000",
               bus_if.stall_pipe, bus_if.rd_valid, bus_if.rd_data);
    end
    @(posedge clk);
    #1;
    last_addr  = 16'd0;
    last_wdata = 16'd0;
    last_rd    = 16'd0;
    $display("txn reset_mid op=%b", OP_LD);
  endtask

  task automatic test_timeout();
    test_access("timeout", OP_LD, 16'h4444, 16'h0, 16'h0, 1, MW + 1, 1'b0);
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({bus_if.err, bus_if.stall_pipe, bus_if.mem_rd, bus_if.mem_addr} !== 19'd0) begin
      n_errors++;
      $display("FAIL timeout_rst err/stall/rd/addr got %b%b%b %h exp 000 0000",
               bus_if.err, bus_if.stall_pipe, bus_if.mem_rd, bus_if.mem_addr);
    end
    @(posedge clk);
    #1;
    $display("txn timeout_reset");
    test_access("after_err", OP_LD, 16'h5555, 16'h0, 16'h1357, 0, 1, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    do_reset();
    test_reset();
    test_access("ld_basic", OP_LD, 16'h1234, 16'h0000, 16'hBEEF, 0, 1, 1'b0);
    test_access("st_busy", OP_ST, 16'h0040, 16'hA5A5, 16'h0000, 3, 2, 1'b0);
    test_nonmem();
    test_flush();
    test_single_cycle();
    test_access("done_at_limit", OP_LD, 16'hABCD, 16'h0, 16'h7E57, 0, MW, 1'b0);
    test_random();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Multi-cycle MEM-stage controller for the pipelined core. It is the successor to the purely combinational MEM decode. It decodes the 5-bit opcode of the instruction in MEM into read or write accesses. It issues a latched request to a variable-latency memory, holds the pipeline with a stall until the access completes, returns load data with a valid strobe, and flags timeouts. It sits between the EX/MEM pipeline register and the data memory (or cache) interface.

Parameters:
OPCODE_W, 5, opcode width; the decode values below are the low 5 bits
ADDR_W, 16, memory address width
DATA_W, 16, memory data width
MAX_WAIT, 15, cycles allowed in WAIT before timeout; legal range 1..255

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high
valid_in  in  1  an instruction is present in MEM this cycle
flush  in  1  squash the MEM instruction; honoured only in IDLE
opcode  in  OPCODE_W  opcode of the MEM instruction
addr_in  in  ADDR_W  effective address from EX
wdata_in  in  DATA_W  store data
mem_busy  in  1  memory cannot accept the request this cycle
mem_done  in  1  memory has completed the outstanding access
mem_rdata  in  DATA_W  read data, valid when mem_done=1
mem_rd  out  1  read request to memory
mem_wr  out  1  write request to memory
mem_addr  out  ADDR_W  latched request address
mem_wdata  out  DATA_W  latched store data
stall_pipe  out  1  hold IF/ID/EX and the EX/MEM register
rd_data  out  DATA_W  captured load data
rd_valid  out  1  one-cycle strobe: rd_data holds new load data
err  out  1  sticky timeout flag

Behaviour:
- Decode (combinational):
  - LD 10001 -> read.
  - ST 10000 and STU 10011 -> write.
  - Every other opcode, including HALT, NOP, branches, jumps, ALU ops and undefined codes -> no access.
- accept = state==IDLE & valid_in & ~flush & (read|write).
- FSM states: IDLE, REQ, WAIT, DONE, ERR.
- IDLE:
  - On accept, latch addr_in, wdata_in and the access kind; go to REQ.
  - Non-memory ops pass through with no stall.
- REQ:
  - mem_rd or mem_wr = 1, with mem_addr/mem_wdata from the latches.
  - If mem_busy=1, stay in REQ and keep the request asserted.
  - If mem_busy=0 and mem_done=1 in the same cycle, go to DONE (single-cycle memory).
  - If mem_busy=0 and mem_done=0, go to WAIT and clear the counter.
- WAIT:
  - Requests are deasserted.
  - On mem_done, go to DONE.
  - Otherwise increment the counter. When the counter == MAX_WAIT-1 and mem_done=0, go to ERR.
  - mem_done on the same cycle the counter reaches its limit wins, i.e. the FSM goes to DONE.
- DONE:
  - For a read, rd_data <= mem_rdata is captured on the DONE-entry edge and rd_valid=1 for exactly this cycle.
  - For a write, rd_valid=0.
  - Return to IDLE.
  - A new accept is not taken in DONE; the next MEM instruction is evaluated in IDLE.
- ERR: err=1, stall_pipe=1, no requests. The FSM stays in ERR until rst.
- stall_pipe = accept | state∈{REQ,WAIT,ERR}. It is 0 in DONE so the pipeline advances exactly on completion.
- Latency: with mem_busy=0 and mem_done one cycle after REQ:
  - accept at cycle 0, REQ at cycle 1, WAIT at cycle 2 (mem_done), DONE at cycle 3.
  - stall_pipe is high for cycles 0-2.
- flush:
  - In IDLE it suppresses accept.
  - In REQ/WAIT it is ignored; an issued access always completes, because stores cannot be cancelled.
- mem_done outside REQ/WAIT is ignored.
- Reset (including mid-access):
  - All outputs 0: mem_rd, mem_wr, mem_addr, mem_wdata, stall_pipe (except via accept after reset), rd_data, rd_valid, err.
  - State is IDLE and the counter is 0.
  - The outstanding access is abandoned.
- Width rules:
  - The counter is 8 bits, so MAX_WAIT must be ≤255.
  - Latched outputs hold their values after DONE until the next accept.

Test Plan:
- LD (10001), addr 0x1234, mem_busy=0, mem_done at WAIT cycle 1 with rdata 0xBEEF -> mem_rd=1 only in cycle 1; stall cycles 0-2; rd_data=0xBEEF with rd_valid=1 in cycle 3 only.
- ST (10000), addr 0x0040, wdata 0xA5A5, mem_busy high for 3 cycles -> mem_wr, mem_addr=0x0040 and mem_wdata=0xA5A5 held for 4 REQ cycles; rd_valid never asserts; stall drops in DONE.
- ADDI (01000) and HALT (00000) with valid_in=1 -> no mem_rd/mem_wr, stall_pipe=0, state stays IDLE.
- STU (10011) with flush=1 in IDLE -> no request. LD accepted, then flush=1 during WAIT -> the access completes normally with rd_valid.
- LD with MAX_WAIT=4 and mem_done never asserted -> err=1 after 4 WAIT cycles; stall_pipe stuck at 1; rst clears err, stall_pipe and state.
- Single-cycle memory: mem_done=1 in REQ -> DONE on the next cycle, 2 stall cycles total. Also assert rst during WAIT -> all outputs 0 the next cycle, and a later mem_done is ignored.
